uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Drains uart_rx into a receive FIFO and exposes it to the d16 CPU bus.
//  - On each uart_rx byte-ready pulse: reads the UART status register, then its data register (clears DA/OV), pushes the byte.
//  - CPU sees a 4-register map: data pop, status, count, control. The interrupt is level-based.
// PARAMETERS
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 bytes (16). Count width = DEPTH_LOG2+1.
// PORTS
//  i_clk      in   1  clock
//  i_reset    in   1  synchronous, active-high reset
//  i_cyc      in   1  CPU bus cycle; one-cycle strobe per access
//  i_we       in   1  CPU write enable
//  i_addr     in   2  CPU register select
//  i_dat      in   8  CPU write data
//  o_dat      out  8  CPU read data, combinational from i_addr
//  o_u_cyc    out  1  UART-side bus cycle
//  o_u_addr   out  1  UART-side register select: 0 = data, 1 = status
//  o_u_we     out  1  UART-side write enable; tied 0
//  i_u_dat    in   8  UART read data; combinational from o_u_addr
//  i_u_int    in   1  uart_rx one-cycle byte-ready pulse
//  o_int      out  1  interrupt to CPU, level
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, count=0, sticky flags=0, IEN=0, pending=0. o_u_cyc/o_u_addr/o_u_we/o_int = 0.
//  A reset mid-sequence aborts with no push; any buffered data is lost.
//  pending flag: set by i_u_int; cleared when FSM leaves IDLE.
//  FSM, UART side:
//   IDLE:    if (pending | i_u_int) -> RD_STAT.
//   RD_STAT: o_u_cyc=1, o_u_addr=1. Capture i_u_dat[1:0].
//            - If bit1 (UART OV): set sticky UOVR.
//            - If bit0 (DA) = 1 -> RD_DATA; else -> IDLE.
//   RD_DATA: o_u_cyc=1, o_u_addr=0, o_u_we=0. Push i_u_dat -> IDLE.
//  Latency: i_u_int at cycle N; RD_STAT at N+1; RD_DATA at N+2; byte visible in count/data at N+3.
//  Push while full: byte dropped, sticky FOVF=1, FIFO unchanged.
//  CPU register map (o_dat is combinational):
//   0 DATA  rd: FIFO head (0x00 if empty). Rd with i_cyc & !i_we pops 1 entry; empty = no pop. wr ignored.
//   1 STAT  rd: {4'b0, UOVR, FOVF, full, !empty}. Rd with i_cyc clears UOVR and FOVF. wr ignored.
//   2 COUNT rd: zero-extended count (0..DEPTH). wr ignored.
//   3 CTRL  rd/wr: bit0 = IEN; other bits per CONFIGURATION.
//  Simultaneous events:
//   - push + pop same cycle: both occur; count unchanged. If full, the push succeeds because the pop frees a slot.
//   - sticky set + STAT read same cycle: set wins.
//  Pointers wrap mod DEPTH; count saturates only through the full check, never exceeds DEPTH.
// CONFIGURATION
//  Macro RX_FIFO_THRESH_INT_EN:
//   Defined:
//    - CTRL[7:4] = THRESH (rd/wr, reset 0). Effective threshold T = THRESH, or 1 when THRESH==0.
//    - o_int = IEN & (count >= T).
//   Undefined:
//    - CTRL[7:4] read 0; writes to them are ignored.
//    - o_int = IEN & !empty.
//  o_int is registered in both cases (one cycle after the count change).
// TESTING
//  1 UART byte 0xA5: pulse i_u_int with stat=2'b01, data=0xA5 -> u-bus status then data cycle; COUNT=1 at N+3; DATA read =0xA5; COUNT=0.
//  2 Spurious pulse, stat=2'b00 -> RD_STAT only, no data cycle, COUNT stays 0.
//  3 Push 17 bytes 0x00..0x10 with DEPTH_LOG2=4:
//     - STAT = 0x07 (FOVF, full, !empty); next STAT = 0x03.
//     - 16 pops return 0x00..0x0F, then a DATA read = 0x00 with no pop.
//  4 FIFO full, CPU pops in the same cycle as RD_DATA -> COUNT stays 16, new byte is tail, FOVF=0.
//  5 UART status 2'b11 -> STAT bit3=1, byte pushed; STAT read clears it.
//  6 IEN=1:
//     - Macro undefined: o_int rises 1 cycle after first push, falls after last pop.
//     - Macro defined with CTRL=0x41: o_int=0 at COUNT=3, o_int=1 at COUNT=4.
//     - Reset mid-RD_STAT: o_u_cyc=0 next cycle, COUNT=0.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl_if.sv
// CPU register bus and UART-side read bus of uart_rx_fifo_ctrl; slave = controller, master = bus owner / testbench.
interface uart_rx_fifo_ctrl_if;
  logic       i_cyc;
  logic       i_we;
  logic [1:0] i_addr;
  logic [7:0] i_dat;
  logic [7:0] o_dat;
  logic       o_u_cyc;
  logic       o_u_addr;
  logic       o_u_we;
  logic [7:0] i_u_dat;
  logic       i_u_int;
  logic       o_int;

  modport slave (
    input  i_cyc, i_we, i_addr, i_dat, i_u_dat, i_u_int,
    output o_dat, o_u_cyc, o_u_addr, o_u_we, o_int
  );

  modport master (
    output i_cyc, i_we, i_addr, i_dat, i_u_dat, i_u_int,
    input  o_dat, o_u_cyc, o_u_addr, o_u_we, o_int
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// Drains uart_rx into a receive FIFO read by the CPU; a byte reaches COUNT/DATA 3 cycles after the pulse, pushes into a full FIFO are dropped (FOVF).
// Optional RX_FIFO_THRESH_INT_EN adds a CTRL[7:4] interrupt threshold; otherwise the interrupt is IEN & !empty.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_rx_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_STAT = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  pending_q, pending_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic                  uovr_q, uovr_d;
  logic                  fovf_q, fovf_d;
  logic                  ien_q, ien_d;
  logic                  int_q, int_d;
  logic [3:0]            ctrl_hi;

  logic empty, full, cpu_rd, cpu_wr, pop, stat_rd, push_req, push, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign cpu_rd   = bus.i_cyc & ~bus.i_we;
  assign cpu_wr   = bus.i_cyc & bus.i_we;
  assign pop      = cpu_rd & (bus.i_addr == 2'd0) & ~empty;
  assign stat_rd  = cpu_rd & (bus.i_addr == 2'd1);
  assign push_req = (state_q == S_RD_DATA);
  // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | bus.i_u_int;
    case (state_q)
      S_IDLE: begin
        if (pending_q | bus.i_u_int) begin
          state_d   = S_RD_STAT;
          pending_d = 1'b0;
        end
      end
      S_RD_STAT: state_d = bus.i_u_dat[0] ? S_RD_DATA : S_IDLE;
      S_RD_DATA: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.i_u_dat;
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Clear-on-read comes first so a same-cycle set survives.
  always_comb begin
    uovr_d = uovr_q;
    fovf_d = fovf_q;
    if (stat_rd) begin
      uovr_d = 1'b0;
      fovf_d = 1'b0;
    end
    if ((state_q == S_RD_STAT) && bus.i_u_dat[1]) uovr_d = 1'b1;
    if (drop) fovf_d = 1'b1;
  end

`ifdef RX_FIFO_THRESH_INT_EN
  logic [3:0]    thresh_q, thresh_d;
  logic [CW-1:0] eff_thresh;

  assign ctrl_hi    = thresh_q;
  assign eff_thresh = (thresh_q == 4'd0) ? CW'(1) : CW'(thresh_q);

  always_comb begin
    ien_d    = ien_q;
    thresh_d = thresh_q;
    if (cpu_wr && (bus.i_addr == 2'd3)) begin
      ien_d    = bus.i_dat[0];
      thresh_d = bus.i_dat[7:4];
    end
    int_d = ien_q & (count_q >= eff_thresh);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) thresh_q <= 4'd0;
    else         thresh_q <= thresh_d;
  end
`else
  assign ctrl_hi = 4'd0;

  always_comb begin
    ien_d = ien_q;
    if (cpu_wr && (bus.i_addr == 2'd3)) ien_d = bus.i_dat[0];
    int_d = ien_q & ~empty;
  end
`endif

  always_comb begin
    case (bus.i_addr)
      2'd0:    bus.o_dat = empty ? 8'h00 : mem_q[rd_ptr_q];
      2'd1:    bus.o_dat = {4'b0000, uovr_q, fovf_q, full, ~empty};
      2'd2:    bus.o_dat = 8'(count_q);
      default: bus.o_dat = {ctrl_hi, 3'b000, ien_q};
    endcase
  end

  assign bus.o_u_cyc  = (state_q == S_RD_STAT) | (state_q == S_RD_DATA);
  assign bus.o_u_addr = (state_q == S_RD_STAT);
  assign bus.o_u_we   = 1'b0;
  assign bus.o_int    = int_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      uovr_q    <= 1'b0;
      fovf_q    <= 1'b0;
      ien_q     <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      uovr_q    <= uovr_d;
      fovf_q    <= fovf_d;
      ien_q     <= ien_d;
      int_q     <= int_d;
    end
  end

  // Storage needs no reset: reads of an empty FIFO return 0 regardless.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed scenarios plus random CPU/UART traffic against a queue-based model.
module tb_uart_rx_fifo_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] u_stat;
  logic [7:0] u_data;

  always #5 clk = ~clk;

  uart_rx_fifo_ctrl_if bus ();

  // UART register file: address 1 = status, 0 = data, combinational.
  assign bus.i_u_dat = bus.o_u_addr ? {6'b000000, u_stat} : u_data;

  uart_rx_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Reference model state
  logic [7:0] q_m[$];
  bit         uovr_m, fovf_m, ien_m, int_m;
  bit  [3:0]  thresh_m;
  int         seq_m;        // cycles since accepted pulse, -1 when UART side idle
  bit  [1:0]  sstat_m;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    uovr_m = 0; fovf_m = 0; ien_m = 0; int_m = 0; thresh_m = 4'd0;
    seq_m = -1; sstat_m = 2'b00;
  endtask

  function automatic bit int_cond();
`ifdef RX_FIFO_THRESH_INT_EN
    int t;
    t = (thresh_m == 4'd0) ? 1 : int'(thresh_m);
    return q_m.size() >= t;
`else
    return q_m.size() != 0;
`endif
  endfunction

  function automatic logic [7:0] exp_dat(input logic [1:0] a);
    case (a)
      2'd0:    return (q_m.size() == 0) ? 8'h00 : q_m[0];
      2'd1:    return {4'b0000, uovr_m, fovf_m, q_m.size() == DEPTH, q_m.size() != 0};
      2'd2:    return 8'(q_m.size());
      default: return {thresh_m, 3'b000, ien_m};
    endcase
  endfunction

  // One clock cycle: drive, check every output against the model, then advance the model.
  task automatic cycle(input bit r, input bit c, input bit w, input logic [1:0] a,
                       input logic [7:0] wd, input bit ui, input logic [1:0] us, input logic [7:0] ud);
    bit new_int;
    @(posedge clk); #1;
    rst = r; bus.i_cyc = c; bus.i_we = w; bus.i_addr = a; bus.i_dat = wd; bus.i_u_int = ui;
    if (ui) begin
      u_stat = us; u_data = ud;
      if (seq_m < 0) begin seq_m = 0; sstat_m = us; end
    end
    #1;
    last_dat = bus.o_dat;
    chk("o_dat", bus.o_dat, exp_dat(a));
    chk("o_int", bus.o_int, int_m);
    chk("o_u_cyc", bus.o_u_cyc, (seq_m == 1) || (seq_m == 2 && sstat_m[0]));
    chk("o_u_addr", bus.o_u_addr, seq_m == 1);
    chk("o_u_we", bus.o_u_we, 0);
    if (r) begin
      model_reset();
      return;
    end
    new_int = ien_m && int_cond();
    if (c && !w && a == 2'd1) begin uovr_m = 0; fovf_m = 0; end
    if (seq_m == 1 && sstat_m[1]) uovr_m = 1;
    if (c && w && a == 2'd3) begin
      ien_m = wd[0];
`ifdef RX_FIFO_THRESH_INT_EN
      thresh_m = wd[7:4];
`endif
    end
    if (c && !w && a == 2'd0 && q_m.size() != 0) void'(q_m.pop_front());
    if (seq_m == 2 && sstat_m[0]) begin
      if (q_m.size() < DEPTH) q_m.push_back(u_data);
      else fovf_m = 1;
    end
    int_m = new_int;
    if (seq_m >= 0) seq_m = (seq_m == 2 || (seq_m == 1 && !sstat_m[0])) ? -1 : seq_m + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 2'd0, 8'h00, 0, 2'b00, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(0, 1, 0, a, 8'h00, 0, 2'b00, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cycle(0, 1, 1, a, d, 0, 2'b00, 8'h00);
  endtask

  task automatic uart_byte(input logic [1:0] s, input logic [7:0] d, input bit pop_at_data);
    cycle(0, 0, 0, 2'd0, 8'h00, 1, s, d);
    idle(1);
    cycle(0, pop_at_data, 0, 2'd0, 8'h00, 0, 2'b00, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_cyc = 0; bus.i_we = 0; bus.i_addr = 2'd0; bus.i_dat = 8'h00; bus.i_u_int = 0;
    u_stat = 2'b00; u_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state
    rd(2'd1); chk("rst_stat", last_dat, 8'h00);
    rd(2'd2); chk("rst_count", last_dat, 8'h00);
    rd(2'd3); chk("rst_ctrl", last_dat, 8'h00);

    // Single byte 0xA5 with exact bus timing
    cycle(0, 0, 0, 2'd0, 8'h00, 1, 2'b01, 8'hA5);
    idle(1); chk("t1_stat_cycle", {bus.o_u_cyc, bus.o_u_addr}, 2'b11);
    idle(1); chk("t1_data_cycle", {bus.o_u_cyc, bus.o_u_addr}, 2'b10);
    rd(2'd2); chk("t1_count", last_dat, 8'd1);
    rd(2'd0); chk("t1_data", last_dat, 8'hA5);
    rd(2'd2); chk("t1_count_after", last_dat, 8'd0);

    // Spurious pulse: status only
    cycle(0, 0, 0, 2'd0, 8'h00, 1, 2'b00, 8'h3C);
    idle(1); chk("t2_stat_cycle", bus.o_u_cyc, 1);
    idle(1); chk("t2_no_data_cycle", bus.o_u_cyc, 0);
    rd(2'd2); chk("t2_count", last_dat, 8'd0);

    // Overflow by one
    for (int i = 0; i <= 16; i++) uart_byte(2'b01, 8'(i), 0);
    rd(2'd1); chk("t3_stat_ovf", last_dat, 8'h07);
    rd(2'd1); chk("t3_stat_clr", last_dat, 8'h03);
    for (int i = 0; i < 16; i++) begin
      rd(2'd0); chk("t3_pop", last_dat, 8'(i));
    end
    rd(2'd0); chk("t3_empty_read", last_dat, 8'h00);
    rd(2'd2); chk("t3_count_empty", last_dat, 8'd0);

    // Full FIFO, pop coincides with the push
    for (int i = 0; i < 16; i++) uart_byte(2'b01, 8'h80 + 8'(i), 0);
    uart_byte(2'b01, 8'hEE, 1); chk("t4_pop_head", last_dat, 8'h80);
    rd(2'd2); chk("t4_count", last_dat, 8'd16);
    rd(2'd1); chk("t4_stat", last_dat, 8'h03);
    for (int i = 1; i < 16; i++) rd(2'd0);
    rd(2'd0); chk("t4_tail", last_dat, 8'hEE);

    // UART overrun flag
    uart_byte(2'b11, 8'h5A, 0);
    rd(2'd1); chk("t5_uovr", last_dat, 8'h09);
    rd(2'd1); chk("t5_uovr_clr", last_dat, 8'h01);
    rd(2'd0); chk("t5_data", last_dat, 8'h5A);

    // Interrupt
`ifdef RX_FIFO_THRESH_INT_EN
    wr(2'd3, 8'h41);
    rd(2'd3); chk("t6_ctrl", last_dat, 8'h41);
    for (int i = 0; i < 3; i++) uart_byte(2'b01, 8'h10 + 8'(i), 0);
    idle(2); chk("t6_int_cnt3", bus.o_int, 0);
    uart_byte(2'b01, 8'h13, 0);
    idle(2); chk("t6_int_cnt4", bus.o_int, 1);
    for (int i = 0; i < 4; i++) rd(2'd0);
    idle(2); chk("t6_int_drained", bus.o_int, 0);
`else
    wr(2'd3, 8'hF1);
    rd(2'd3); chk("t6_ctrl", last_dat, 8'h01);
    uart_byte(2'b01, 8'h77, 0);
    idle(1); chk("t6_int_not_yet", bus.o_int, 0);
    idle(1); chk("t6_int_rise", bus.o_int, 1);
    rd(2'd0);
    idle(1); chk("t6_int_hold", bus.o_int, 1);
    idle(1); chk("t6_int_fall", bus.o_int, 0);
`endif
    wr(2'd3, 8'h00);

    // Reset during RD_STAT discards buffered and in-flight data
    uart_byte(2'b01, 8'h22, 0);
    cycle(0, 0, 0, 2'd0, 8'h00, 1, 2'b01, 8'h11);
    cycle(1, 0, 0, 2'd0, 8'h00, 0, 2'b00, 8'h00);
    idle(1); chk("t7_u_cyc", bus.o_u_cyc, 0);
    rd(2'd2); chk("t7_count", last_dat, 8'd0);

    // Random traffic: pop-light then pop-heavy
    for (int k = 0; k < 3000; k++) begin
      bit         ui, c, w;
      logic [1:0] a, us;
      logic [7:0] wd, ud;
      ui = (seq_m < 0) && ($urandom_range(0, 2) == 0);
      us = {($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0)};
      ud = 8'($urandom);
      c  = ($urandom_range(0, 1) == 1);
      w  = ($urandom_range(0, 5) == 0);
      a  = 2'($urandom_range(0, 3));
      if (k >= 1500 && $urandom_range(0, 1) == 1) begin a = 2'd0; w = 0; end
      wd = 8'($urandom);
      cycle(0, c, w, a, wd, ui, us, ud);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
